// File: rtl/seq_sub64.sv
// ----------------------------------------------------------------------------
// seq_sub64 -- multi-cycle subtractor, diff = a - b - bin (mod 2^WIDTH)
//
// Handles one SLICE_W-bit slice per clock, least-significant slice first.
// The borrow between slices is carried in a register. This is the
// area-reduced inverse path next to the combinational CLA adder.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   request, accepted only while ready=1
//   in_a   in   minuend, sampled on the accepting edge
//   in_b   in   subtrahend, sampled on the accepting edge
//   bin    in   borrow-in, sampled on the accepting edge
//   ready  out  high in IDLE only
//   busy   out  high in RUN
//   done   out  one-cycle pulse; result and flags are valid from here on
//   diff   out  result register
//   bout   out  final borrow-out (unsigned in_a < in_b + bin)
//   zero   out  diff == 0
//   ovf    out  signed overflow of the subtraction
// ----------------------------------------------------------------------------
module seq_sub64 #(
    parameter int WIDTH   = 64,
    parameter int SLICE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    // A one-slice build still needs a one-bit counter to stay well-formed.
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [CW-1:0]       cnt_r;
    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic [WIDTH-1:0]    work_r;
    logic                borrow_r;
    logic [WIDTH-1:0]    diff_r;
    logic                bout_r;
    logic                zero_r;
    logic                ovf_r;

    logic [SLICE_W-1:0]  a_slice_s;
    logic [SLICE_W-1:0]  b_slice_s;
    logic [SLICE_W:0]    sum_s;
    logic                borrow_next_s;
    logic [WIDTH-1:0]    work_next_s;
    logic                last_slice_s;

    assign last_slice_s = (cnt_r == LAST_SLICE);

    // Slice arithmetic: a - b - borrow done as a + ~b + ~borrow, borrow = ~carry.
    always_comb begin
        a_slice_s   = a_r[cnt_r*SLICE_W +: SLICE_W];
        b_slice_s   = b_r[cnt_r*SLICE_W +: SLICE_W];
        sum_s       = {1'b0, a_slice_s} + {1'b0, ~b_slice_s}
                    + {{SLICE_W{1'b0}}, ~borrow_r};
        borrow_next_s = ~sum_s[SLICE_W];
        work_next_s = work_r;
        work_next_s[cnt_r*SLICE_W +: SLICE_W] = sum_s[SLICE_W-1:0];
    end

    // Next-state decode for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_slice_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch, slice walk and result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= {CW{1'b0}};
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            work_r   <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            diff_r   <= {WIDTH{1'b0}};
            bout_r   <= 1'b0;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_r      <= in_a;
                        b_r      <= in_b;
                        borrow_r <= bin;
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                S_RUN: begin
                    work_r   <= work_next_s;
                    borrow_r <= borrow_next_s;
                    cnt_r    <= cnt_r + CW'(1);
                    // Results stay frozen until the final slice lands.
                    if (last_slice_s) begin
                        diff_r <= work_next_s;
                        bout_r <= borrow_next_s;
                        zero_r <= (work_next_s == {WIDTH{1'b0}});
                        ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                  (work_next_s[WIDTH-1] != a_r[WIDTH-1]);
                    end
                end
                S_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign ready = (state_r == S_IDLE);
    assign busy  = (state_r == S_RUN);
    assign done  = (state_r == S_DONE);
    assign diff  = diff_r;
    assign bout  = bout_r;
    assign zero  = zero_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_seq_sub64.sv
// ----------------------------------------------------------------------------
// tb_seq_sub64 -- self-checking bench for seq_sub64 at default parameters.
// Directed corner cases plus random back-to-back operations, compared with
// a plain 65-bit arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_seq_sub64;

    localparam int NSLICE = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        bin;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    // Last completed result as predicted by the model (reset value is 0).
    logic [63:0] exp_diff = 64'd0;
    logic        exp_bout = 1'b0;
    logic        exp_zero = 1'b0;
    logic        exp_ovf  = 1'b0;

    seq_sub64 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in_a  (in_a),
        .in_b  (in_b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision subtraction; bit 64 is the borrow.
    function automatic logic [64:0] ref_sub(input logic [63:0] a, input logic [63:0] b,
                                            input logic bi);
        return {1'b0, a} - {1'b0, b} - {64'd0, bi};
    endfunction

    // Called just after the accepting edge; walks to done and checks the result.
    task automatic wait_done(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic bi);
        logic [64:0] r;
        int lat;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            lat = n;
            if (done) break;
            check({tag, "_hold"}, {64'd0, diff, bout, zero, ovf},
                  {64'd0, exp_diff, exp_bout, exp_zero, exp_ovf});
        end
        check({tag, "_latency"}, lat, NSLICE);
        r = ref_sub(a, b, bi);
        exp_diff = r[63:0];
        exp_bout = r[64];
        exp_zero = (r[63:0] == 64'd0);
        exp_ovf  = (a[63] != b[63]) && (r[63] != a[63]);
        check({tag, "_diff"}, diff, exp_diff);
        check({tag, "_flags"}, {bout, zero, ovf, ready}, {exp_bout, exp_zero, exp_ovf, 1'b0});
        @(posedge clk); #1;
        check({tag, "_after"}, {done, ready}, {1'b0, 1'b1});
    endtask

    // Single operation from IDLE with start dropped after acceptance.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic bi);
        in_a = a; in_b = b; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; bin = 1'($urandom % 2);
        check({tag, "_busy"}, {busy, ready}, {1'b1, 1'b0});
        wait_done(tag, a, b, bi);
    endtask

    initial begin
        int snap;
        int last_acc;
        logic [63:0] ca, cb;
        logic cbi;
        rst = 1'b1; start = 1'b0; in_a = 64'd0; in_b = 64'd0; bin = 1'b0;
        #12;
        check("reset", {ready, busy, done, diff, bout, zero, ovf},
              {1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op("basic", 64'd5, 64'd3, 1'b0);
        run_op("ripple", 64'd0, 64'd1, 1'b0);
        run_op("sovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        run_op("equal", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0);
        run_op("eq_bin", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1);

        // Start pulsed during RUN must be ignored.
        snap = done_cnt;
        in_a = 64'd10; in_b = 64'd4; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in_a = 64'd1; in_b = 64'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("ign_diff", diff, 64'd6);
        check("ign_pulses", done_cnt - snap, 1);
        check("ign_ready", ready, 1'b1);
        exp_diff = 64'd6; exp_bout = 1'b0; exp_zero = 1'b0; exp_ovf = 1'b0;

        // Reset in the middle of RUN aborts with no done pulse.
        snap = done_cnt;
        in_a = 64'd10; in_b = 64'd4; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort", {ready, busy, done, diff, bout, zero, ovf},
              {1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk); rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_pulses", done_cnt - snap, 0);
        exp_diff = 64'd0; exp_bout = 1'b0; exp_zero = 1'b0; exp_ovf = 1'b0;
        run_op("post_rst", 64'd7, 64'd7, 1'b0);

        // Back-to-back with start held high.
        start = 1'b1;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; bin = 1'($urandom % 2);
        last_acc = 0;
        for (int i = 0; i < 9; i++) begin
            for (int w = 0; w < 20 && !ready; w++) begin
                @(posedge clk); #1;
            end
            check("b2b_ready", ready, 1'b1);
            ca = in_a; cb = in_b; cbi = bin;
            @(posedge clk); #1;
            if (i > 0) check("b2b_interval", cyc - last_acc, NSLICE + 2);
            last_acc = cyc;
            in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; bin = 1'($urandom % 2);
            wait_done("b2b", ca, cb, cbi);
        end
        start = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_sub64.md
Name: seq_sub64

Overview:
- Multi-cycle 64-bit subtractor. Computes diff = a - b - bin, processing one SLICE_W-bit slice per clock, least-significant slice first.
- The borrow ripples between slices through a register.
- Companion to the combinational 64-bit CLA adder: it is the inverse arithmetic path, area-reduced for the datapath's subtract/compare operations.
- Uses a start/ready/done handshake and produces registered borrow, zero and signed-overflow flags.

Parameters:
- WIDTH, 64: operand and result width.
- SLICE_W, 16: bits processed per RUN cycle. WIDTH must be an integer multiple of SLICE_W; NSLICE = WIDTH/SLICE_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; accepted only when ready=1.
- in_a  input  WIDTH  minuend, sampled on the accepting edge.
- in_b  input  WIDTH  subtrahend, sampled on the accepting edge.
- bin  input  1  borrow-in, sampled on the accepting edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result and flags valid from this cycle on.
- diff  output  WIDTH  result register.
- bout  output  1  final borrow-out: 1 iff unsigned in_a < in_b + bin.
- zero  output  1  1 iff diff == 0.
- ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset (rst=1, asynchronous):
  - state = IDLE, slice counter = 0.
  - Operand, work and borrow registers cleared.
  - ready=1, busy=0, done=0, diff=0, bout=0, zero=0, ovf=0.
  - Takes effect immediately, including mid-RUN. An aborted operation never pulses done.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1: latch in_a, in_b, set borrow register = bin, counter = 0, go to RUN.
  - start=0: stay.
- RUN, each edge, with k = counter:
  - {c, s} = a[k] + ~b[k] + ~borrow, computed at SLICE_W+1 bits.
  - Work register slice k <= s; borrow <= ~c; counter <= k+1.
  - After the edge that computes slice NSLICE-1: go to DONE, and copy work register (with the final slice merged) into diff, final borrow into bout, and compute zero and ovf from the latched operands and the new diff.
- DONE:
  - done=1 for exactly this cycle, ready=0.
  - Next edge returns to IDLE unconditionally.
- Latency: done is high after the NSLICE-th edge following the accepting edge (4 edges at defaults). Accept-to-accept minimum is NSLICE+2 edges.
- start while RUN or DONE is ignored. Operands are not resampled and there is no queueing.
- diff, bout, zero and ovf hold the previous result throughout RUN. They change only on entry to DONE or on reset.
- Input changes after the accepting edge have no effect on the current operation.
- Counter width is ceil(log2(NSLICE)) bits minimum, with no wrap before DONE. With NSLICE=1, RUN lasts one edge.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

Test Plan:
- Basic subtract: in_a=5, in_b=3, bin=0, start pulse in IDLE -> after 4 edges done=1 for one cycle, diff=2, bout=0, zero=0, ovf=0; next cycle ready=1.
- Full borrow ripple: in_a=0, in_b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0, zero=0.
- Signed overflow: in_a=0x8000_0000_0000_0000, in_b=1, bin=0 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0.
- Equality and borrow-in:
  - in_a=in_b=0x0123_4567_89AB_CDEF, bin=0 -> diff=0, zero=1, bout=0.
  - Same operands with bin=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, zero=0.
- Ignored start and mid-op reset:
  - Start with in_a=10, in_b=4. Pulse start with new operands in_a=1, in_b=2 on RUN edge 2 -> result diff=6, only one done pulse.
  - Repeat, then assert rst in RUN cycle 2 -> immediately ready=1, diff=0, flags 0, no done pulse. A subsequent op (7-7) gives zero=1.
- Back-to-back with start held high and $random operands (each bin = $random % 2), 9 ops -> accepted every 6 edges at defaults. Each {bout, diff} matches a reference model of (a - b - bin) mod 2^65, borrow = a < b + bin.
